// File: rtl/global_pool_if.sv
// Streaming handshake bundle for global_pool.
//   i_data/i_valid/i_ready/i_last/i_mode : one CHANNELS-wide input pixel per beat
//   o_data/o_valid/o_ready/o_last        : single pooled output pixel
//   o_count/o_overflow                   : pixels accumulated / image too large
// master = upstream+downstream side, slave = the pooling block.
interface global_pool_if #(
  parameter int unsigned VALUE_BITS = 32,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CNT_BITS   = 13
);
  logic [CHANNELS-1:0][VALUE_BITS-1:0] i_data;
  logic                                i_valid;
  logic                                i_ready;
  logic                                i_last;
  logic [1:0]                          i_mode;
  logic [CHANNELS-1:0][VALUE_BITS-1:0] o_data;
  logic                                o_valid;
  logic                                o_ready;
  logic                                o_last;
  logic [CNT_BITS-1:0]                 o_count;
  logic                                o_overflow;

  modport master (
    output i_data, i_valid, i_last, i_mode, o_ready,
    input  i_ready, o_data, o_valid, o_last, o_count, o_overflow
  );

  modport slave (
    input  i_data, i_valid, i_last, i_mode, o_ready,
    output i_ready, o_data, o_valid, o_last, o_count, o_overflow
  );
endinterface

// File: rtl/global_pool.sv
// Per-channel global pooling: collapses a stream of CHANNELS-wide pixels
// (ended by i_last) into one output pixel using SUM, AVG or MAX.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : global_pool_if.slave (pixel stream in, pooled pixel out)
module global_pool #(
  parameter int unsigned VALUE_BITS       = 32,
  parameter int unsigned VALUE_Q_FORMAT_N = 16,
  parameter int unsigned CHANNELS         = 4,
  parameter int unsigned MAX_PIXELS       = 4096
) (
  input logic           clk,
  input logic           reset,
  global_pool_if.slave  bus
);
  localparam int unsigned CNT_BITS = $clog2(MAX_PIXELS + 1);
  localparam int unsigned ACC_BITS = VALUE_BITS + $clog2(MAX_PIXELS);
  localparam int unsigned DIV_BITS = $clog2(ACC_BITS + 1);
  localparam logic [1:0]  MODE_AVG = 2'd1;
  localparam logic [1:0]  MODE_MAX = 2'd2;

  // Input and output share the Q format, so pooling never rescales.
  if (VALUE_Q_FORMAT_N >= VALUE_BITS) begin : g_bad_q_format
    $error("global_pool: VALUE_Q_FORMAT_N must be below VALUE_BITS");
  end

  typedef enum logic [1:0] {ACCUM, DIVIDE, OUTPUT} state_t;
  typedef logic signed [ACC_BITS-1:0] acc_t;
  typedef logic [CHANNELS-1:0][VALUE_BITS-1:0] pix_t;

  state_t              state, state_nxt;
  acc_t                acc [CHANNELS];
  acc_t                acc_nxt [CHANNELS];
  logic [ACC_BITS-1:0] quo [CHANNELS];      // dividend shifts out, quotient shifts in
  logic [ACC_BITS-1:0] quo_nxt [CHANNELS];
  logic [CNT_BITS-1:0] rem [CHANNELS];
  logic [CNT_BITS-1:0] rem_nxt [CHANNELS];
  logic [CHANNELS-1:0] neg, neg_nxt;
  logic [CNT_BITS-1:0] count, count_nxt;
  logic [1:0]          mode, mode_nxt;
  logic                overflow, overflow_nxt;
  logic [DIV_BITS-1:0] div_cnt, div_cnt_nxt;
  pix_t                o_data_nxt;
  logic                o_valid_nxt;
  logic [CNT_BITS-1:0] o_count_nxt;
  logic                o_overflow_nxt;

  function automatic acc_t sext(input logic [VALUE_BITS-1:0] v);
    return {{(ACC_BITS-VALUE_BITS){v[VALUE_BITS-1]}}, v};
  endfunction

  // Clamp a wide signed value into the output range.
  function automatic logic [VALUE_BITS-1:0] sat(input logic [ACC_BITS:0] v);
    logic [ACC_BITS-VALUE_BITS+1:0] top;
    top = v[ACC_BITS:VALUE_BITS-1];
    if (top == '0 || top == '1) return v[VALUE_BITS-1:0];
    else if (v[ACC_BITS])       return {1'b1, {(VALUE_BITS-1){1'b0}}};
    else                        return {1'b0, {(VALUE_BITS-1){1'b1}}};
  endfunction

  // State register and all datapath/output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ACCUM;
      count          <= '0;
      mode           <= '0;
      overflow       <= 1'b0;
      div_cnt        <= '0;
      neg            <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        acc[c] <= '0;
        quo[c] <= '0;
        rem[c] <= '0;
      end
      bus.i_ready    <= 1'b0;
      bus.o_valid    <= 1'b0;
      bus.o_last     <= 1'b0;
      bus.o_data     <= '0;
      bus.o_count    <= '0;
      bus.o_overflow <= 1'b0;
    end else begin
      state          <= state_nxt;
      count          <= count_nxt;
      mode           <= mode_nxt;
      overflow       <= overflow_nxt;
      div_cnt        <= div_cnt_nxt;
      neg            <= neg_nxt;
      acc            <= acc_nxt;
      quo            <= quo_nxt;
      rem            <= rem_nxt;
      bus.i_ready    <= (state_nxt == ACCUM);
      bus.o_valid    <= o_valid_nxt;
      bus.o_last     <= o_valid_nxt;
      bus.o_data     <= o_data_nxt;
      bus.o_count    <= o_count_nxt;
      bus.o_overflow <= o_overflow_nxt;
    end
  end

  // Next-state, accumulate, divide and output capture.
  always_comb begin
    logic [1:0]          eff_mode;
    acc_t                din;
    logic [CNT_BITS:0]   rem_sh;
    logic [ACC_BITS:0]   qx;

    state_nxt      = state;
    acc_nxt        = acc;
    quo_nxt        = quo;
    rem_nxt        = rem;
    neg_nxt        = neg;
    count_nxt      = count;
    mode_nxt       = mode;
    overflow_nxt   = overflow;
    div_cnt_nxt    = div_cnt;
    o_data_nxt     = bus.o_data;
    o_valid_nxt    = bus.o_valid;
    o_count_nxt    = bus.o_count;
    o_overflow_nxt = bus.o_overflow;
    din            = '0;
    rem_sh         = '0;
    qx             = '0;
    // Mode is live from the pins only on an image's first beat.
    eff_mode       = (count == '0) ? bus.i_mode : mode;

    unique case (state)
      ACCUM: begin
        if (bus.i_valid && bus.i_ready) begin
          if (count == '0) begin
            mode_nxt  = bus.i_mode;
            count_nxt = CNT_BITS'(1);
            for (int c = 0; c < int'(CHANNELS); c++) acc_nxt[c] = sext(bus.i_data[c]);
          end else if (count == CNT_BITS'(MAX_PIXELS)) begin
            overflow_nxt = 1'b1;
          end else begin
            count_nxt = count + CNT_BITS'(1);
            for (int c = 0; c < int'(CHANNELS); c++) begin
              din = sext(bus.i_data[c]);
              if (mode == MODE_MAX) acc_nxt[c] = (din > acc[c]) ? din : acc[c];
              else                  acc_nxt[c] = acc[c] + din;
            end
          end

          if (bus.i_last) begin
            if (eff_mode == MODE_AVG) begin
              state_nxt   = DIVIDE;
              div_cnt_nxt = '0;
              for (int c = 0; c < int'(CHANNELS); c++) begin
                neg_nxt[c] = acc_nxt[c][ACC_BITS-1];
                quo_nxt[c] = neg_nxt[c] ? ACC_BITS'(-acc_nxt[c]) : ACC_BITS'(acc_nxt[c]);
                rem_nxt[c] = '0;
              end
            end else begin
              state_nxt      = OUTPUT;
              o_valid_nxt    = 1'b1;
              o_count_nxt    = count_nxt;
              o_overflow_nxt = overflow_nxt;
              for (int c = 0; c < int'(CHANNELS); c++)
                o_data_nxt[c] = sat({acc_nxt[c][ACC_BITS-1], acc_nxt[c]});
            end
          end
        end
      end

      DIVIDE: begin
        // One restoring step per cycle; magnitude only, sign re-applied at the end.
        for (int c = 0; c < int'(CHANNELS); c++) begin
          rem_sh = {rem[c], quo[c][ACC_BITS-1]};
          if (rem_sh >= {1'b0, count}) begin
            rem_nxt[c] = CNT_BITS'(rem_sh - {1'b0, count});
            quo_nxt[c] = {quo[c][ACC_BITS-2:0], 1'b1};
          end else begin
            rem_nxt[c] = CNT_BITS'(rem_sh);
            quo_nxt[c] = {quo[c][ACC_BITS-2:0], 1'b0};
          end
        end
        div_cnt_nxt = div_cnt + DIV_BITS'(1);
        if (div_cnt == DIV_BITS'(ACC_BITS - 1)) begin
          state_nxt      = OUTPUT;
          o_valid_nxt    = 1'b1;
          o_count_nxt    = count;
          o_overflow_nxt = overflow;
          for (int c = 0; c < int'(CHANNELS); c++) begin
            qx = {1'b0, quo_nxt[c]};
            if (neg[c]) qx = -qx;
            o_data_nxt[c] = sat(qx);
          end
        end
      end

      OUTPUT: begin
        if (bus.o_ready) begin
          state_nxt      = ACCUM;
          o_valid_nxt    = 1'b0;
          o_overflow_nxt = 1'b0;
          count_nxt      = '0;
          overflow_nxt   = 1'b0;
          for (int c = 0; c < int'(CHANNELS); c++) acc_nxt[c] = '0;
        end
      end

      default: state_nxt = ACCUM;
    endcase
  end
endmodule
